mem_stage: RTL

//  Memory-access pipeline stage between exe_stage and wb_stage. Latches es_to_ms_bus and waits for the

---
 rtl/mem_stage_pkg.sv | 33 +++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_stage.sv | 70 +++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, load-op encodings and bus layouts shared by the MEM stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 107;
  localparam int MS_TO_WS_BUS_WD = 71;
  localparam int MAX_DISCARD = 3;
  typedef enum logic [2:0] {
    LD_LW   = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LWL  = 3'd5,
    LD_LWR  = 3'd6,
    LD_NONE = 3'd7
  } ld_op_e;
  typedef struct packed {
    logic        ex;
    logic        req_issued;
    ld_op_e      ld_op;
    logic [31:0] rt_val;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;
  typedef struct packed {
    logic        ex;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake, memory response and bypass signals around the MEM stage
interface mem_stage_if;
  import mem_stage_pkg::*;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
  logic                       WS_EX;
  logic                       MS_EX;
  logic [4:0]                 MEM_dest;
  logic [31:0]                MEM_dest_data;
  logic                       MEM_load_pending;
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, WS_EX,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, MS_EX, MEM_dest, MEM_dest_data, MEM_load_pending
  );
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, WS_EX,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, MS_EX, MEM_dest, MEM_dest_data, MEM_load_pending
  );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: selects, extends and merges load data by op and byte offset
module mem_load_align
  import mem_stage_pkg::*;
(
  input  ld_op_e      ld_op,
  input  logic [1:0]  a,
  input  logic [31:0] data,
  input  logic [31:0] rt_val,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lmask;
  logic [31:0] rmask;
  assign b = data[{a, 3'b000} +: 8];
  assign h = a[1] ? data[31:16] : data[15:0];
  assign lmask = 32'hFFFF_FFFF << {~a, 3'b000};
  assign rmask = 32'hFFFF_FFFF >> {a, 3'b000};
  // lwl/lwr keep the untouched bytes of rt_val; everything else comes from memory
  always_comb
    result = ld_op == LD_LB  ? {{24{b[7]}}, b} :
             ld_op == LD_LBU ? {24'd0, b} :
             ld_op == LD_LH  ? {{16{h[15]}}, h} :
             ld_op == LD_LHU ? {16'd0, h} :
             ld_op == LD_LWL ? ((data << {~a, 3'b000}) & lmask) | (rt_val & ~lmask) :
             ld_op == LD_LWR ? ((data >> {a, 3'b000}) & rmask) | (rt_val & ~rmask) :
             data;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage waiting on data_ok, aligning loads and dropping stale responses
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave m
);
  es_to_ms_t   bus_r;
  ms_to_ws_t   out;
  logic        ms_valid;
  logic        data_buf_valid;
  logic [31:0] data_buf;
  logic [1:0]  discard_cnt;
  logic        resp_ok;
  logic        wait_resp;
  logic        ms_ready_go;
  logic [31:0] mem_data;
  logic [31:0] aligned;
  logic [31:0] final_result;
  assign resp_ok = m.data_sram_data_ok && discard_cnt == 2'd0;
  assign wait_resp = ms_valid & bus_r.req_issued & ~bus_r.ex & ~data_buf_valid;
  assign ms_ready_go = ~wait_resp | resp_ok;
  assign m.ms_allowin = ~ms_valid | (ms_ready_go & m.ws_allowin);
  assign m.ms_to_ws_valid = ms_valid & ms_ready_go;
  assign mem_data = data_buf_valid ? data_buf : m.data_sram_rdata;
  mem_load_align u_align (
    .ld_op (bus_r.ld_op),
    .a     (bus_r.alu_result[1:0]),
    .data  (mem_data),
    .rt_val(bus_r.rt_val),
    .result(aligned)
  );
  assign final_result = (bus_r.ex || bus_r.ld_op == LD_NONE) ? bus_r.alu_result : aligned;
  assign out = '{ex: bus_r.ex, gr_we: bus_r.gr_we, dest: bus_r.dest, final_result: final_result, pc: bus_r.pc};
  assign m.ms_to_ws_bus = out;
  assign m.MS_EX = ms_valid & bus_r.ex;
  assign m.MEM_dest = bus_r.dest & {5{ms_valid & bus_r.gr_we}};
  assign m.MEM_dest_data = final_result;
  assign m.MEM_load_pending = bus_r.gr_we & wait_resp & ~resp_ok;
  // stage valid and bus latch; a flush kills both the resident and any entering instruction
  always_ff @(posedge clk)
    if (reset) begin
      ms_valid <= 1'b0;
      bus_r <= '0;
    end else begin
      if (m.WS_EX) ms_valid <= 1'b0;
      else if (m.ms_allowin) ms_valid <= m.es_to_ms_valid;
      if (m.es_to_ms_valid && m.ms_allowin) bus_r <= es_to_ms_t'(m.es_to_ms_bus);
    end
  // hold response data while WB stalls so data_ok is not lost
  always_ff @(posedge clk)
    if (reset || m.WS_EX) data_buf_valid <= 1'b0;
    else if (m.ms_to_ws_valid && m.ws_allowin) data_buf_valid <= 1'b0;
    else if (wait_resp && resp_ok && !m.ws_allowin) begin
      data_buf_valid <= 1'b1;
      data_buf <= m.data_sram_rdata;
    end
  // count responses still owed to flushed requests; a data_ok during a flush of a waiter cancels out
  always_ff @(posedge clk)
    if (reset) discard_cnt <= 2'd0;
    else if (m.WS_EX && wait_resp && !m.data_sram_data_ok)
      discard_cnt <= discard_cnt == 2'(MAX_DISCARD) ? discard_cnt : discard_cnt + 2'd1;
    else if (m.data_sram_data_ok && discard_cnt != 2'd0 && !(m.WS_EX && wait_resp))
      discard_cnt <= discard_cnt - 2'd1;
  // more outstanding stale responses than the counter can track would be a pipeline bug
  always_ff @(posedge clk)
    if (!reset && m.WS_EX && wait_resp && !m.data_sram_data_ok)
      assert (discard_cnt != 2'(MAX_DISCARD));
endmodule
